// File: rtl/banco_registradores_wb_if.sv
// Decode / write-back bus of the MIPS register file: read ports, write-back strobe,
// issue request and the scoreboard status returned to decode.
interface banco_registradores_wb_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic [AW-1:0] rs_addr;
    logic [AW-1:0] rt_addr;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic          RegWrite;
    logic [AW-1:0] reg_destino;
    logic [DW-1:0] dado_escrita;
    logic          issue_valid;
    logic [AW-1:0] issue_dest;
    logic          stall;
    logic [5:0]    pend_count;

    modport master (
        output rs_addr, rt_addr, RegWrite, reg_destino, dado_escrita,
               issue_valid, issue_dest,
        input  rs_data, rt_data, stall, pend_count
    );

    modport slave (
        input  rs_addr, rt_addr, RegWrite, reg_destino, dado_escrita,
               issue_valid, issue_dest,
        output rs_data, rt_data, stall, pend_count
    );
endinterface

// File: rtl/banco_registradores_wb.sv
// 32x32 MIPS register file with pending-write scoreboard and decode stall.
// Optional macro BANCO_FORWARD_EN: write-through of same-cycle write-back to the read ports.
module banco_registradores_wb #(
    parameter int NREG   = 32,
    parameter int DWIDTH = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    banco_registradores_wb_if.slave  bus
);
    localparam int AW = $clog2(NREG);

    logic [DWIDTH-1:0] r_regs [NREG];
    logic [NREG-1:0]   r_pending;
    logic [5:0]        r_pendCount;

    logic              w_write;
    logic              w_issue;
    logic              w_rsBusy;
    logic              w_rtBusy;
    logic [NREG-1:0]   w_pendingNext;
    logic [5:0]        w_popCount;
    logic [DWIDTH-1:0] w_rsData;
    logic [DWIDTH-1:0] w_rtData;

    assign w_write = bus.RegWrite && (bus.reg_destino != '0);
    assign w_issue = bus.issue_valid && !bus.stall && (bus.issue_dest != '0);

    // A register being written back this cycle is still busy unless forwarding is built in.
    always_comb begin
        w_rsBusy = r_pending[bus.rs_addr] && (bus.rs_addr != '0);
        w_rtBusy = r_pending[bus.rt_addr] && (bus.rt_addr != '0);
`ifdef BANCO_FORWARD_EN
        if (w_write && (bus.reg_destino == bus.rs_addr)) begin
            w_rsBusy = 1'b0;
        end
        if (w_write && (bus.reg_destino == bus.rt_addr)) begin
            w_rtBusy = 1'b0;
        end
`endif
    end

    always_comb begin
        w_rsData = (bus.rs_addr == '0) ? '0 : r_regs[bus.rs_addr];
        w_rtData = (bus.rt_addr == '0) ? '0 : r_regs[bus.rt_addr];
`ifdef BANCO_FORWARD_EN
        if (w_write && (bus.reg_destino == bus.rs_addr)) begin
            w_rsData = bus.dado_escrita;
        end
        if (w_write && (bus.reg_destino == bus.rt_addr)) begin
            w_rtData = bus.dado_escrita;
        end
`endif
    end

    // Clear first so that a same-cycle issue to the same index (the newer producer) wins.
    always_comb begin
        w_pendingNext = r_pending;
        if (w_write) begin
            w_pendingNext[bus.reg_destino] = 1'b0;
        end
        if (w_issue) begin
            w_pendingNext[bus.issue_dest] = 1'b1;
        end
        w_pendingNext[0] = 1'b0;
    end

    always_comb begin
        w_popCount = '0;
        for (int i = 1; i < NREG; i++) begin
            w_popCount = w_popCount + 6'(w_pendingNext[i]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
            r_pending   <= '0;
            r_pendCount <= '0;
        end else begin
            if (w_write) begin
                r_regs[bus.reg_destino] <= bus.dado_escrita;
            end
            r_pending   <= w_pendingNext;
            r_pendCount <= w_popCount;
        end
    end

    assign bus.rs_data    = w_rsData;
    assign bus.rt_data    = w_rtData;
    assign bus.stall      = w_rsBusy | w_rtBusy;
    assign bus.pend_count = r_pendCount;

    logic [AW-1:0] w_unusedAw;
    assign w_unusedAw = '0;
endmodule
